// File: rtl/parity_checker.sv
// Bit-serial parity checker: counts ones of a received word over WIDTH
// shift cycles and checks them against the received parity bit.
module parity_checker #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             parity_in,
  input  logic             odd_mode,
  output logic             busy,
  output logic             done,
  output logic             parity_ok,
  output logic             parity_err,
  output logic [CW-1:0]    ones_count,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMPARE
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic             p_reg;
  logic             m_reg;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    bit_cnt;
  logic             fail;

  // Ones in word plus parity bit must match the expected mode's parity.
  assign fail = acc[0] ^ p_reg ^ m_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      p_reg      <= 1'b0;
      m_reg      <= 1'b0;
      acc        <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      parity_ok  <= 1'b0;
      parity_err <= 1'b0;
      ones_count <= '0;
      err_count  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= data_in;
            p_reg     <= parity_in;
            m_reg     <= odd_mode;
            acc       <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          acc       <= acc + CW'(shift_reg[0]);
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= bit_cnt + CW'(1);
          if (bit_cnt == LAST) begin
            state <= COMPARE;
          end
        end
        COMPARE: begin
          parity_err <= fail;
          parity_ok  <= ~fail;
          ones_count <= acc;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
          if (fail && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
